// File: rtl/color_sequencer.sv
// RGB colour sequencer: walks an 8-entry palette in STATIC, CYCLE, BLINK or
// FADE mode, paced by a clock prescaler and a tick-based step counter.
module color_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int STEP_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_mode,
  input  logic       btn_color,
  output logic [5:0] rgb_pwm,
  output logic [1:0] mode,
  output logic       step_strobe
);

  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_CYCLE  = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_FADE   = 2'b11
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          phase_on_q, phase_on_d;
  logic [1:0]    lvl_q, lvl_d;
  logic          dir_up_q, dir_up_d;
  logic [5:0]    rgb_q, rgb_d;
  logic          strobe_q, strobe_d;
  logic          tick, step;
  logic [5:0]    pal_next;

  function automatic logic [5:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 6'b110000;
      3'd1:    palette = 6'b110100;
      3'd2:    palette = 6'b111100;
      3'd3:    palette = 6'b001100;
      3'd4:    palette = 6'b001111;
      3'd5:    palette = 6'b000011;
      3'd6:    palette = 6'b110011;
      default: palette = 6'b111111;
    endcase
  endfunction

  assign tick = enable && (presc_q == PRESC_LAST);
  assign step = tick && (step_cnt_q == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_STATIC;
      idx_q      <= 3'd0;
      presc_q    <= '0;
      step_cnt_q <= '0;
      phase_on_q <= 1'b1;
      lvl_q      <= 2'd0;
      dir_up_q   <= 1'b1;
      rgb_q      <= 6'b000000;
      strobe_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      phase_on_q <= phase_on_d;
      lvl_q      <= lvl_d;
      dir_up_q   <= dir_up_d;
      rgb_q      <= rgb_d;
      strobe_q   <= strobe_d;
    end
  end

  // Priority: disabled, then btn_mode, then btn_color, then the sequence step.
  // Any button cycle clears the pacing state and swallows a coincident step.
  always_comb begin
    mode_d     = mode_q;
    idx_d      = idx_q;
    presc_d    = presc_q;
    step_cnt_d = step_cnt_q;
    phase_on_d = phase_on_q;
    lvl_d      = lvl_q;
    dir_up_d   = dir_up_q;
    strobe_d   = 1'b0;

    if (!enable || btn_mode || btn_color) begin
      presc_d    = '0;
      step_cnt_d = '0;
      phase_on_d = 1'b1;
      lvl_d      = 2'd0;
      dir_up_d   = 1'b1;
      if (enable && btn_mode)
        mode_d = mode_t'(mode_q + 2'd1);
      else if (enable && btn_color)
        idx_d = idx_q + 3'd1;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick)
        step_cnt_d = step ? '0 : step_cnt_q + SW'(1);
      if (step) begin
        strobe_d = 1'b1;
        case (mode_q)
          MODE_CYCLE: idx_d = idx_q + 3'd1;
          MODE_BLINK: phase_on_d = !phase_on_q;
          MODE_FADE: begin
            if (dir_up_q) begin
              lvl_d = lvl_q + 2'd1;
              if (lvl_q == 2'd2)
                dir_up_d = 1'b0;
            end else begin
              lvl_d = lvl_q - 2'd1;
              if (lvl_q == 2'd1) begin
                dir_up_d = 1'b1;
                idx_d    = idx_q + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The colour word is built from the next state so it lands together with it.
  always_comb begin
    pal_next = palette(idx_d);
    rgb_d    = 6'b000000;
    if (enable) begin
      case (mode_d)
        MODE_BLINK: rgb_d = phase_on_d ? pal_next : 6'b000000;
        MODE_FADE: begin
          rgb_d[5:4] = (pal_next[5:4] != 2'd0) ? lvl_d : 2'd0;
          rgb_d[3:2] = (pal_next[3:2] != 2'd0) ? lvl_d : 2'd0;
          rgb_d[1:0] = (pal_next[1:0] != 2'd0) ? lvl_d : 2'd0;
        end
        default: rgb_d = pal_next;
      endcase
    end
  end

  assign rgb_pwm     = rgb_q;
  assign mode        = mode_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Randomised scoreboard bench for color_sequencer; the reference model tracks
// mode, base index and elapsed enabled clocks/steps since the last clear.
module tb_color_sequencer;

  localparam int TD = 2;
  localparam int ST = 2;
  localparam int P  = TD * ST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_color = 1'b0;
  logic [5:0] rgb_pwm;
  logic [1:0] mode;
  logic       step_strobe;

  typedef struct {
    logic [5:0] rgb;
    logic [1:0] mode;
    logic       strobe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  logic [5:0] pal_tbl [8] = '{6'b110000, 6'b110100, 6'b111100, 6'b001100,
                              6'b001111, 6'b000011, 6'b110011, 6'b111111};
  int         fade_lvl [6] = '{0, 1, 2, 3, 2, 1};

  int m_mode = 0;
  int m_base = 0;
  int m_cyc  = 0;
  int m_nst  = 0;

  color_sequencer #(.TICK_DIV(TD), .STEP_TICKS(ST)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .btn_mode(btn_mode),
    .btn_color(btn_color),
    .rgb_pwm(rgb_pwm),
    .mode(mode),
    .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout reached before end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  function automatic int cur_idx();
    case (m_mode)
      1:       return (m_base + m_nst) % 8;
      3:       return (m_base + m_nst / 6) % 8;
      default: return m_base;
    endcase
  endfunction

  function automatic logic [5:0] color_now();
    logic [5:0] pal;
    logic [5:0] res;
    logic [1:0] lvl;
    pal = pal_tbl[cur_idx()];
    res = pal;
    if (m_mode == 2 && (m_nst % 2) != 0)
      res = 6'b000000;
    if (m_mode == 3) begin
      lvl = 2'(fade_lvl[m_nst % 6]);
      for (int f = 0; f < 3; f++)
        res[2*f +: 2] = (pal[2*f +: 2] != 2'd0) ? lvl : 2'd0;
    end
    return res;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic m,
                            input logic c, output exp_t x);
    x.strobe = 1'b0;
    if (!r) begin
      m_mode = 0; m_base = 0; m_cyc = 0; m_nst = 0;
    end else if (!e) begin
      m_base = cur_idx(); m_cyc = 0; m_nst = 0;
    end else if (m) begin
      m_base = cur_idx(); m_mode = (m_mode + 1) % 4; m_cyc = 0; m_nst = 0;
    end else if (c) begin
      m_base = (cur_idx() + 1) % 8; m_cyc = 0; m_nst = 0;
    end else begin
      if (m_cyc % P == P - 1) begin
        m_nst++;
        x.strobe = 1'b1;
      end
      m_cyc++;
    end
    x.mode = 2'(m_mode);
    x.rgb  = (r && e) ? color_now() : 6'b000000;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one clock's worth of inputs well away from the edge and queue the
  // response expected right after the next rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic m, input logic c);
    exp_t x;
    @(posedge clk);
    #2;
    rst_n = r; enable = e; btn_mode = m; btn_color = c;
    model_edge(r, e, m, c, x);
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("rgb_pwm", {2'b00, rgb_pwm}, {2'b00, x.rgb});
        checkOutput("mode", {6'b0, mode}, {6'b0, x.mode});
        checkOutput("step_strobe", {7'b0, step_strobe}, {7'b0, x.strobe});
      end
    end
  end

  initial begin : stimulus
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (36) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (60) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    // Both buttons land exactly on the fourth clock after a clear, i.e. a step.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("async_reset_rgb", {2'b00, rgb_pwm}, 8'h00);
    checkOutput("async_reset_mode", {6'b0, mode}, 8'h00);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 499) != 0),
                    ($urandom_range(0, 19) != 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 29) == 0));
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
